vram_portb_arbiter: RTL and testbench
=====================================

VRAM_PORTB_ARBITER -- requirements
Module: vram_portb_arbiter

Interface
REQ-001 Parameter AW, default 15, sets the port-B word address width.
REQ-002 Parameter DW, default 128, sets the port-B data width (16 samples x 8 bit).
REQ-003 Parameter RD_LAT, default 2, is the RAM cycles from a registered address_b to valid q_b.
REQ-004 Parameter MAX_BURST, default 16, is the maximum number of consecutive locked grants.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 rN_req  in  1  requester N (N=0 vector unit, N=1 FIR stream engine) access request.
REQ-008 rN_lock  in  1  requester N asks to keep ownership for the next beat.
REQ-009 rN_we  in  1  write (1) or read (0).
REQ-010 rN_addr  in  AW  word address.
REQ-011 rN_wdata  in  DW  write data.
REQ-012 rN_gnt  out  1  combinational; the request is accepted in this cycle.
REQ-013 rN_rvalid  out  1  read data valid for requester N.
REQ-014 rN_rdata  out  DW  read data, the shared q_b.
REQ-015 address_b  out  AW  registered RAM port-B address.
REQ-016 data_b  out  DW  registered RAM port-B write data.
REQ-017 wren_b  out  1  registered RAM port-B write enable.
REQ-018 q_b  in  DW  RAM port-B read data.

Function
REQ-019 Handshake: rN_req and its qualifiers are held stable until rN_gnt is high; the access is accepted on that clock edge.
REQ-020 At most one rN_gnt is high per cycle; with no rN_req high, no grant is issued.
REQ-021 Round-robin: on a conflict, the requester not granted most recently wins; the pointer updates on every grant.
REQ-022 Lock: after a grant to N with rN_lock high, N is the owner; while the owner keeps rN_req high, it wins regardless of the pointer.
REQ-023 Burst counter: counts consecutive owner grants; after MAX_BURST, a requesting non-owner wins the next cycle and ownership is cleared.
REQ-024 If the other requester is idle when MAX_BURST is reached, ownership continues and the counter restarts at 1.
REQ-025 Ownership also ends when the owner deasserts rN_req or grants with rN_lock low.
REQ-026 Command register: in the edge after a grant cycle, address_b and data_b load the winner's values and wren_b loads rN_we.
REQ-027 In non-grant cycles, wren_b is 0 and address_b/data_b hold their values.
REQ-028 Read return: for a read granted in cycle G, rN_rvalid is high for exactly one cycle at G+1+RD_LAT, tagged to the correct N.
REQ-029 A tag shift register of depth RD_LAT+1 gives back-to-back reads a throughput of one per cycle, with results in grant order.
REQ-030 Writes produce no rvalid.
REQ-031 rN_rdata always equals q_b and is meaningful only while rN_rvalid is high.

Reset
REQ-032 While reset is low: all rN_gnt=0, wren_b=0, address_b=0, data_b=0, all rvalid=0, tag pipeline cleared, pointer favours r0, no owner, burst count=0.
REQ-033 Reset asserted mid-burst or with reads in flight discards those reads; no rvalid appears after release.

Configuration
REQ-034 VRAM_ARB_FIXED_PRIO_EN defined: r0 strictly wins every conflict, lock and MAX_BURST are ignored, and r1 may starve.
REQ-035 VRAM_ARB_FIXED_PRIO_EN undefined: round-robin with lock/burst behaviour as in REQ-021..REQ-025.

Verification
REQ-036 r0 and r1 read continuously from reset (r0_addr=0x0010, r1_addr=0x0200): grants alternate r0,r1,r0,...; each rvalid arrives 3 cycles after its grant with RD_LAT=2.
REQ-037 r1 locked burst of 20 reads while r0 requests: r1 gets 16 consecutive grants, r0 the 17th, then r1 resumes.
REQ-038 r0 writes 0x0F..00 at 0x0004, then reads 0x0004 back to back: wren_b high one cycle; read returns the written pattern; no rvalid for the write.
REQ-039 reset dropped 1 cycle after three back-to-back r1 reads are granted: no r1_rvalid observed after reset release; address_b=0.
REQ-040 Both requesters always request, VRAM_ARB_FIXED_PRIO_EN defined: r0_gnt high every cycle and r1_gnt never high over 100 cycles.

Source files
------------

// File: rtl/vram_portb_arbiter_if.sv
// ============================================================================
// Module      : vram_portb_arbiter_if
// Description : Requester-side bundle for the VRAM port-B arbiter: request
//               with lock/write qualifiers, combinational grant and the read
//               return (rvalid + shared read data).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vram_portb_arbiter_if #(
  parameter int AW = 15,
  parameter int DW = 128
);
  logic          req;
  logic          lock;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  // Requester side drives the request, the arbiter answers
  modport master (output req, lock, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, lock, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

`default_nettype wire

// File: rtl/vram_portb_arbiter.sv
// ============================================================================
// Module      : vram_portb_arbiter
// Description : Two-requester arbiter for VRAM port B (r0 vector unit, r1 FIR
//               stream engine). Round-robin with lock/burst ownership, a
//               registered RAM command stage and a read-tag pipeline that
//               routes q_b back to the requester that issued the read.
//               Optional build macro VRAM_ARB_FIXED_PRIO_EN: r0 strictly wins
//               every conflict, lock and burst limit are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_portb_arbiter #(
  parameter int AW        = 15,
  parameter int DW        = 128,
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 16
) (
  input  wire logic             clk,
  input  wire logic             reset,
  vram_portb_arbiter_if.slave   r0,
  vram_portb_arbiter_if.slave   r1,
  output logic [AW-1:0]         address_b,
  output logic [DW-1:0]         data_b,
  output logic                  wren_b,
  input  wire logic [DW-1:0]    q_b
);

  localparam int            CW        = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_R0   = 2'd1,
    OWN_R1   = 2'd2
  } owner_e;

  logic          gnt0;
  logic          gnt1;
  owner_e        owner_q, owner_d;
  logic          last_q, last_d;      // requester granted most recently (1 = r1)
  logic [CW-1:0] burst_q, burst_d;    // consecutive grants to the current owner
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          wren_q, wren_d;
  logic [RD_LAT:0] tv_q, tv_d;        // read-in-flight valid per pipeline stage
  logic [RD_LAT:0] tid_q, tid_d;      // requester id per pipeline stage

  // Arbitration: choose at most one winner, then update pointer and ownership
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    owner_d = owner_q;
    last_d  = last_q;
    burst_d = burst_q;
`ifdef VRAM_ARB_FIXED_PRIO_EN
    gnt0    = r0.req;
    gnt1    = r1.req & ~r0.req;
    owner_d = OWN_NONE;
    burst_d = '0;
    if (gnt0) begin
      last_d = 1'b0;
    end else if (gnt1) begin
      last_d = 1'b1;
    end
`else
    // Owner keeps the port unless its burst is used up and the other side waits
    if (owner_q == OWN_R0 && r0.req) begin
      if (burst_q == BURST_MAX && r1.req) gnt1 = 1'b1;
      else                                gnt0 = 1'b1;
    end else if (owner_q == OWN_R1 && r1.req) begin
      if (burst_q == BURST_MAX && r0.req) gnt0 = 1'b1;
      else                                gnt1 = 1'b1;
    end else if (r0.req && r1.req) begin
      if (last_q) gnt0 = 1'b1;
      else        gnt1 = 1'b1;
    end else begin
      gnt0 = r0.req;
      gnt1 = r1.req;
    end

    // A locked grant starts or extends ownership; the counter wraps to 1 when
    // the owner continues past the limit because nobody else was waiting
    if (gnt0) begin
      last_d = 1'b0;
      if (r0.lock) begin
        owner_d = OWN_R0;
        burst_d = (owner_q == OWN_R0 && burst_q != BURST_MAX) ? burst_q + 1'b1 : CW'(1);
      end else begin
        owner_d = OWN_NONE;
        burst_d = '0;
      end
    end else if (gnt1) begin
      last_d = 1'b1;
      if (r1.lock) begin
        owner_d = OWN_R1;
        burst_d = (owner_q == OWN_R1 && burst_q != BURST_MAX) ? burst_q + 1'b1 : CW'(1);
      end else begin
        owner_d = OWN_NONE;
        burst_d = '0;
      end
    end else begin
      owner_d = OWN_NONE;
      burst_d = '0;
    end
`endif
  end

  // Command stage and read-tag pipeline: load winner's command, shift tags
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    wren_d = 1'b0;
    tv_d   = '0;
    tid_d  = '0;
    if (gnt0) begin
      addr_d = r0.addr;
      data_d = r0.wdata;
      wren_d = r0.we;
    end else if (gnt1) begin
      addr_d = r1.addr;
      data_d = r1.wdata;
      wren_d = r1.we;
    end
    tv_d[0]  = (gnt0 & ~r0.we) | (gnt1 & ~r1.we);
    tid_d[0] = gnt1;
    for (int i = 1; i <= RD_LAT; i++) begin
      tv_d[i]  = tv_q[i-1];
      tid_d[i] = tid_q[i-1];
    end
  end

  // State registers, cleared asynchronously so in-flight reads are dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= OWN_NONE;
      last_q  <= 1'b1;
      burst_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      tv_q    <= '0;
      tid_q   <= '0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      tv_q    <= tv_d;
      tid_q   <= tid_d;
    end
  end

  // Grants are suppressed while reset is held low
  assign r0.gnt    = gnt0 & reset;
  assign r1.gnt    = gnt1 & reset;
  assign r0.rvalid = tv_q[RD_LAT] & ~tid_q[RD_LAT];
  assign r1.rvalid = tv_q[RD_LAT] &  tid_q[RD_LAT];
  assign r0.rdata  = q_b;
  assign r1.rdata  = q_b;
  assign address_b = addr_q;
  assign data_b    = data_q;
  assign wren_b    = wren_q;

endmodule

`default_nettype wire

// File: tb/tb_vram_portb_arbiter.sv
// ============================================================================
// Module      : tb_vram_portb_arbiter
// Description : Directed self-checking bench for vram_portb_arbiter with a
//               behavioural RAM (RD_LAT=2) and a read-return scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vram_portb_arbiter;
  localparam int AW = 15;
  localparam int DW = 128;
  localparam logic [127:0] PAT = 128'h0F0E0D0C0B0A09080706050403020100;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] address_b;
  logic [DW-1:0] data_b;
  logic          wren_b;
  logic [DW-1:0] q_b;
  logic          ram_load;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_errors = 0;

  logic [DW-1:0] ram    [0:1023];
  logic [DW-1:0] shadow [0:1023];
  logic [DW-1:0] pipe0, pipe1;
  bit            exp_v0 [0:4095];
  bit            exp_v1 [0:4095];
  logic [DW-1:0] exp_d0 [0:4095];
  logic [DW-1:0] exp_d1 [0:4095];

  vram_portb_arbiter_if #(.AW(AW), .DW(DW)) r0_if ();
  vram_portb_arbiter_if #(.AW(AW), .DW(DW)) r1_if ();

  vram_portb_arbiter #(.AW(AW), .DW(DW), .RD_LAT(2), .MAX_BURST(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .r0        (r0_if),
    .r1        (r1_if),
    .address_b (address_b),
    .data_b    (data_b),
    .wren_b    (wren_b),
    .q_b       (q_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] init_word(input int a);
    logic [15:0] h;
    h = a[15:0] ^ 16'hA5A5;
    return {8{h}};
  endfunction

  // Behavioural RAM: registered address -> q_b two cycles later
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
    end else if (wren_b) begin
      ram[address_b[9:0]] <= data_b;
    end
    pipe0 <= ram[address_b[9:0]];
    pipe1 <= pipe0;
  end
  assign q_b = pipe1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Sample at the falling edge: one-hot grant, record expected returns, check returns
  task automatic sample();
    @(negedge clk);
    check("gnt_onehot", 128'(r0_if.gnt & r1_if.gnt), 128'd0);
    if (r0_if.gnt) begin
      if (r0_if.we) shadow[r0_if.addr[9:0]] = r0_if.wdata;
      else begin exp_v0[cyc+3] = 1'b1; exp_d0[cyc+3] = shadow[r0_if.addr[9:0]]; end
    end
    if (r1_if.gnt) begin
      if (r1_if.we) shadow[r1_if.addr[9:0]] = r1_if.wdata;
      else begin exp_v1[cyc+3] = 1'b1; exp_d1[cyc+3] = shadow[r1_if.addr[9:0]]; end
    end
    if (r0_if.rvalid || exp_v0[cyc]) begin
      check("r0_rvalid", 128'(r0_if.rvalid), 128'(exp_v0[cyc]));
      if (exp_v0[cyc]) check("r0_rdata", r0_if.rdata, exp_d0[cyc]);
      exp_v0[cyc] = 1'b0;
    end
    if (r1_if.rvalid || exp_v1[cyc]) begin
      check("r1_rvalid", 128'(r1_if.rvalid), 128'(exp_v1[cyc]));
      if (exp_v1[cyc]) check("r1_rdata", r1_if.rdata, exp_d1[cyc]);
      exp_v1[cyc] = 1'b0;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    r0_if.req = 1'b0; r0_if.lock = 1'b0; r0_if.we = 1'b0;
    r1_if.req = 1'b0; r1_if.lock = 1'b0; r1_if.we = 1'b0;
  endtask

  task automatic drain(input int n);
    idle_all();
    for (int i = 0; i < n; i++) begin sample(); adv(); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1;
    bit done0, done1;
    reset = 1'b0;
    ram_load = 1'b1;
    idle_all();
    r0_if.addr = '0; r0_if.wdata = '0;
    r1_if.addr = '0; r1_if.wdata = '0;
    for (int i = 0; i < 1024; i++) shadow[i] = init_word(i);
    adv();
    adv();

    // Reset state, with both requests raised while reset is low
    r0_if.req = 1'b1; r1_if.req = 1'b1;
    sample();
    check("rst_gnt0", r0_if.gnt, 0);
    check("rst_gnt1", r1_if.gnt, 0);
    check("rst_wren_b", wren_b, 0);
    check("rst_address_b", address_b, 0);
    check("rst_data_b", data_b, 0);
    check("rst_rvalid", {r0_if.rvalid, r1_if.rvalid}, 0);
    ram_load = 1'b0;
    idle_all();
    adv();
    reset = 1'b1;

`ifndef VRAM_ARB_FIXED_PRIO_EN
    // Continuous reads from both: alternate r0,r1,... with 3-cycle return
    r0_if.req = 1'b1; r0_if.addr = 15'h0010;
    r1_if.req = 1'b1; r1_if.addr = 15'h0200;
    for (int i = 0; i < 12; i++) begin
      sample();
      check("rr_gnt0", r0_if.gnt, (i % 2) == 0);
      check("rr_gnt1", r1_if.gnt, (i % 2) == 1);
      if (i > 0) check("rr_address_b", address_b, ((i % 2) == 1) ? 128'h10 : 128'h200);
      if (i >= 3) check("rr_rvalid0", r0_if.rvalid, (i % 2) == 1);
      adv();
    end
    drain(4);

    // r1 locked 20-read burst, r0 waits: 16 r1, then r0, then r1 resumes
    n1 = 0; done0 = 1'b0;
    r0_if.addr = 15'h0020;
    r1_if.lock = 1'b1;
    for (int j = 0; j < 21; j++) begin
      r1_if.req  = (n1 < 20);
      r1_if.addr = AW'(32'h300 + n1);
      r0_if.req  = (j >= 1) && !done0;
      sample();
      check("burst_gnt0", r0_if.gnt, j == 16);
      check("burst_gnt1", r1_if.gnt, j != 16);
      if (r0_if.gnt) done0 = 1'b1;
      if (r1_if.gnt) n1++;
      adv();
    end
    check("burst_total_r1", n1, 20);
    drain(4);

    // r0 locked alone past the limit keeps ownership (counter restarts),
    // then an unlocked beat hands over to the waiting r1
    n0 = 0; done1 = 1'b0;
    r1_if.addr = 15'h0210;
    for (int j = 0; j < 21; j++) begin
      r0_if.req  = (n0 < 20);
      r0_if.lock = (n0 < 18);
      r0_if.addr = AW'(32'h100 + n0);
      r1_if.req  = (j >= 17) && !done1;
      sample();
      check("restart_gnt0", r0_if.gnt, j != 19);
      check("restart_gnt1", r1_if.gnt, j == 19);
      if (r0_if.gnt) n0++;
      if (r1_if.gnt) done1 = 1'b1;
      adv();
    end
    drain(4);
`endif

    // r0 write then immediate read-back of the same word
    r0_if.req = 1'b1; r0_if.we = 1'b1; r0_if.lock = 1'b0;
    r0_if.addr = 15'h0004; r0_if.wdata = PAT;
    sample();
    check("wr_gnt", r0_if.gnt, 1);
    adv();
    r0_if.we = 1'b0;
    sample();
    check("wr_wren_b", wren_b, 1);
    check("wr_address_b", address_b, 4);
    check("wr_data_b", data_b, PAT);
    check("rd_gnt", r0_if.gnt, 1);
    adv();
    idle_all();
    sample();
    check("rd_wren_b", wren_b, 0);
    check("idle_address_hold", address_b, 4);
    adv();
    sample();
    check("wr_no_rvalid", r0_if.rvalid, 0);
    adv();
    sample();
    check("rd_rvalid", r0_if.rvalid, 1);
    check("rd_rdata", r0_if.rdata, PAT);
    adv();
    drain(3);

    // Three back-to-back r1 reads, reset one cycle later discards them
    r1_if.req = 1'b1; r1_if.we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      r1_if.addr = AW'(32'h40 + k);
      sample();
      check("inflight_gnt1", r1_if.gnt, 1);
      adv();
    end
    idle_all();
    reset = 1'b0;
    for (int i = 0; i < 4096; i++) begin exp_v0[i] = 1'b0; exp_v1[i] = 1'b0; end
    sample();
    check("inrst_rvalid1", r1_if.rvalid, 0);
    adv();
    sample();
    adv();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sample();
      check("postrst_rvalid1", r1_if.rvalid, 0);
      check("postrst_address_b", address_b, 0);
      adv();
    end

`ifdef VRAM_ARB_FIXED_PRIO_EN
    // Fixed priority: r0 wins every cycle, r1 starves
    r0_if.req = 1'b1; r0_if.addr = 15'h0010;
    r1_if.req = 1'b1; r1_if.addr = 15'h0200; r1_if.lock = 1'b1;
    for (int i = 0; i < 100; i++) begin
      sample();
      check("fixed_gnt0", r0_if.gnt, 1);
      check("fixed_gnt1", r1_if.gnt, 0);
      adv();
    end
    drain(4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
